// File: rtl/umi_regbank.sv
// UMI register bank: eight byte-addressable registers on the adapter's reg_* bus.
// Define UMI_REGBANK_LOCK_EN to build the set-only LOCK register at index 7.
module umi_regbank #(
  parameter int              AW      = 64,
  parameter int              RW      = 64,
  parameter logic [RW-1:0]   ID      = '0,
  parameter logic [RW-1:0]   CTRLRST = '0
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic [AW-1:0] reg_addr,
  input  logic          reg_write,
  input  logic          reg_read,
  input  logic [2:0]    reg_size,
  input  logic [RW-1:0] reg_wrdata,
  output logic [RW-1:0] reg_rddata,
  output logic [RW-1:0] ctrl,
  input  logic [RW-1:0] status,
  input  logic [RW-1:0] irq_set,
  output logic          irq
);

  localparam int NB = RW / 8;
  localparam int LW = $clog2(NB);

  logic [2:0]    idx;
  logic [LW-1:0] off;
  logic [LW-1:0] lane_mask;
  logic [LW-1:0] off_al;
  logic [2:0]    size_eff;
  logic [NB-1:0] wbe;
  logic [NB-1:0] rbe;
  logic [RW-1:0] wmask;
  logic [RW-1:0] rmask;
  logic [RW-1:0] wdata_sh;

  logic [RW-1:0] scratch_q, ctrl_q, istat_q, ien_q, cnt_q;
  logic [RW-1:0] scratch_nx, ctrl_nx, istat_nx, ien_nx, cnt_nx;
  logic [RW-1:0] rd_tgt;
  logic [RW-1:0] rd_val;
  logic [RW-1:0] lock_rd;
  logic          locked;
  logic          wr_scratch, wr_ctrl, wr_istat, wr_ien, wr_cnt;

  logic unused_addr;
  assign unused_addr = ^reg_addr[AW-1:LW+3];

  // Lane decode: access size clamps to the register width, offset aligns down to it
  always_comb begin
    idx       = reg_addr[LW +: 3];
    off       = reg_addr[LW-1:0];
    size_eff  = (reg_size > 3'(LW)) ? 3'(LW) : reg_size;
    lane_mask = LW'((32'd1 << size_eff) - 32'd1);
    off_al    = off & ~lane_mask;
    wbe       = '0;
    rbe       = '0;
    wmask     = '0;
    rmask     = '0;
    for (int b = 0; b < NB; b++) begin
      wbe[b]          = ((LW'(b) & ~lane_mask) == off_al);
      rbe[b]          = ((LW'(b) & ~lane_mask) == '0);
      wmask[8*b +: 8] = {8{wbe[b]}};
      rmask[8*b +: 8] = {8{rbe[b]}};
    end
    wdata_sh = reg_wrdata << {off_al, 3'b000};
  end

  function automatic logic [RW-1:0] merge(input logic [RW-1:0] cur,
                                          input logic [RW-1:0] mask,
                                          input logic [RW-1:0] data);
    return (cur & ~mask) | (data & mask);
  endfunction

  assign wr_scratch = reg_write && (idx == 3'd1) && !locked;
  assign wr_ctrl    = reg_write && (idx == 3'd2) && !locked;
  assign wr_istat   = reg_write && (idx == 3'd4);
  assign wr_ien     = reg_write && (idx == 3'd5) && !locked;
  assign wr_cnt     = reg_write && (idx == 3'd6);

  // Interrupt set pulses override a same-cycle W1C; a COUNT write beats the increment
  always_comb begin
    scratch_nx = wr_scratch ? merge(scratch_q, wmask, wdata_sh) : scratch_q;
    ctrl_nx    = wr_ctrl    ? merge(ctrl_q, wmask, wdata_sh)    : ctrl_q;
    ien_nx     = wr_ien     ? merge(ien_q, wmask, wdata_sh)     : ien_q;
    istat_nx   = (istat_q & ~(wr_istat ? (wdata_sh & wmask) : '0)) | irq_set;
    cnt_nx     = wr_cnt     ? merge(cnt_q, wmask, wdata_sh)     : cnt_q + RW'(1);
  end

`ifdef UMI_REGBANK_LOCK_EN
  logic lock_q;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset)
      lock_q <= 1'b0;
    else if (reg_write && (idx == 3'd7) && wmask[0] && wdata_sh[0])
      lock_q <= 1'b1;
  end

  assign locked  = lock_q;
  assign lock_rd = {{(RW-1){1'b0}}, lock_q};
`else
  assign locked  = 1'b0;
  assign lock_rd = '0;
`endif

  always_comb begin
    case (idx)
      3'd0:    rd_tgt = ID;
      3'd1:    rd_tgt = scratch_q;
      3'd2:    rd_tgt = ctrl_q;
      3'd3:    rd_tgt = status;
      3'd4:    rd_tgt = istat_q;
      3'd5:    rd_tgt = ien_q;
      3'd6:    rd_tgt = cnt_q;
      default: rd_tgt = lock_rd;
    endcase
    rd_val = (rd_tgt >> {off_al, 3'b000}) & rmask;
  end

  // Read data only moves on a read strobe so read-modify-write sees a stable value
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      scratch_q  <= '0;
      ctrl_q     <= CTRLRST;
      istat_q    <= '0;
      ien_q      <= '0;
      cnt_q      <= '0;
      irq        <= 1'b0;
      reg_rddata <= '0;
    end else begin
      scratch_q <= scratch_nx;
      ctrl_q    <= ctrl_nx;
      istat_q   <= istat_nx;
      ien_q     <= ien_nx;
      cnt_q     <= cnt_nx;
      irq       <= |(istat_nx & ien_nx);
      if (reg_read)
        reg_rddata <= rd_val;
    end
  end

  assign ctrl = ctrl_q;

endmodule

// File: doc/umi_regbank.md
Name: umi_regbank

Overview:
- Register bank that sits directly downstream of the UMI register-interface adapter and consumes its reg_* bus.
- Holds eight RW-bit registers:
  - ID
  - scratch
  - control
  - status mirror
  - sticky interrupt status (W1C)
  - interrupt enable
  - cycle counter
  - optional lock register
- Returns registered read data that stays stable between reads, so the adapter's read-modify-write atomics work.

Parameters:
- AW, 64, address width.
- RW, 64, register width; power of two, >=32.
- ID, 0, value returned by register 0.
- CTRLRST, 0, reset value of CTRL.

Ports:
- clk  input  1  clock
- nreset  input  1  async active-low reset
- reg_addr  input  AW  byte address
- reg_write  input  1  write strobe, one cycle
- reg_read  input  1  read strobe, one cycle
- reg_size  input  3  log2 access bytes
- reg_wrdata  input  RW  write data, LSB-aligned
- reg_rddata  output  RW  read data, LSB-aligned, registered
- ctrl  output  RW  CTRL register contents
- status  input  RW  live status sampled on read
- irq_set  input  RW  per-bit interrupt set pulses
- irq  output  1  registered OR of (IRQ_STATUS & IRQ_ENABLE)

Behaviour:
- Reset is nreset, asynchronous, active-low; clock is clk. All flops use an async reset.
- Reset values:
  - reg_rddata = 0, irq = 0, ctrl = CTRLRST.
  - SCRATCH, IRQ_STATUS, IRQ_ENABLE, COUNT, LOCK = 0.
- Decode:
  - Lane offset: off = reg_addr[log2(RW/8)-1:0].
  - Register index: reg_addr[log2(RW/8)+:3].
  - Higher address bits are ignored; group filtering is done upstream.
- Access bytes: nb = min(1<<reg_size, RW/8). off is aligned down to a multiple of nb.
- Write: bytes [off, off+nb) of the target receive reg_wrdata bytes [0, nb). Other bytes are unchanged. The write takes effect on the clock edge.
- Read: on the reg_read edge, reg_rddata <= (target >> 8*off), masked to nb bytes with upper bits zero.
  - reg_rddata holds that value until the next reg_read.
  - Read latency is 1 cycle.
- Register map by index:
  - 0 ID: RO, returns ID.
  - 1 SCRATCH: RW.
  - 2 CTRL: RW, drives ctrl.
  - 3 STATUS: RO, returns status input sampled at the read edge.
  - 4 IRQ_STATUS: next = (cur & ~wmask_clear) | irq_set.
    - wmask_clear = written bits that are 1.
    - A set and a clear of the same bit in the same cycle leaves the bit set (set wins).
  - 5 IRQ_ENABLE: RW.
  - 6 COUNT: increments by 1 every cycle and wraps from all-ones to 0. A write loads the written bytes; the write takes priority over the increment that cycle. A read returns the pre-edge value.
  - 7 LOCK: see Optional Feature.
- Writes to RO registers are ignored with no error.
- reg_read and reg_write asserted together (adapter atomic overlap): the read samples the pre-write value, and the write updates the register.
- irq: registered; irq <= |(IRQ_STATUS_next & IRQ_ENABLE_next). Assertion lags irq_set by 1 cycle.
- Async reset mid-access: everything returns to reset values immediately, and no write completes.

Optional Feature:
- Macro: UMI_REGBANK_LOCK_EN.
- Defined:
  - Index 7 is LOCK. Bit0 is set-only: writing 1 sets it, writing 0 has no effect; only reset clears it.
  - While LOCK[0]=1, writes to SCRATCH, CTRL and IRQ_ENABLE are ignored.
  - IRQ_STATUS W1C and COUNT remain writable.
  - Reads of index 7 return {0, LOCK[0]}.
- Undefined:
  - Index 7 reads 0 and writes are ignored.
  - No lock flop is synthesised.

Test Plan:
- Reset, then read index 0 with ID=0x1234, size=3 -> reg_rddata=0x1234 one cycle after reg_read. ctrl=CTRLRST and irq=0 during and after reset.
- Byte-lane write: write SCRATCH addr 0x0C (off=4) size=1 data 0xBEEF over prior 0x1111111111111111, then 64-bit read:
  - expected = 0x1111BEEF11111111.
  - A 2-byte read at off=4 returns 0xBEEF.
- Interrupts: irq_set[3] pulse, IRQ_ENABLE=0x8 -> irq=1 one cycle later.
  - Writing 0x8 to IRQ_STATUS clears it, and irq drops the next cycle.
  - A simultaneous irq_set[3] and W1C 0x8 leaves the bit set and irq stays 1.
- Counter: write COUNT=0xFFFFFFFFFFFFFFFE, read 2 cycles later -> value wrapped to 0x0. A write in the same cycle as the increment -> written value is held exactly.
- Atomic overlap: reg_read on CTRL (value 5), with reg_write 7 on the following cycle and a read issued concurrently -> first reg_rddata=5, then ctrl=7.
- With UMI_REGBANK_LOCK_EN: write LOCK=1, then write CTRL=0xFF -> ctrl unchanged. Writing LOCK=0 does not unlock. Reset unlocks. Without the macro, index 7 always reads 0.
